// File: rtl/sram_buf_pkg.sv
// ----------------------------------------------------------------------------
// sram_buf_pkg
// Shared definitions for the banked SRAM activation buffer:
//   - default configuration constants (used as the top-level parameter defaults)
//   - bank addressing widths for the default configuration
//   - response record type for the default configuration
//   - extend(): widens a read word to the response width, sign- or zero-filled
// ----------------------------------------------------------------------------
package sram_buf_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_BANK_DEPTH = 32768;
    localparam int DEF_NUM_BANKS  = 6;
    localparam int DEF_ADDR_W     = 18;
    localparam int DEF_OUT_W      = 32;
    localparam int DEF_RSP_DEPTH  = 3;

    localparam int BANK_AW    = $clog2(DEF_BANK_DEPTH);
    localparam int BANK_IDX_W = $clog2(DEF_NUM_BANKS);

    // Widest response word extend() can produce; OUT_W must not exceed it.
    localparam int EXT_MAX_W = 64;

    typedef struct packed {
        logic [DEF_OUT_W-1:0] data;
        logic                 err;
    } rsp_t;

    // Copies the low data_w bits of data and fills everything above with
    // either the data MSB (sign_ext=1) or zero.
    function automatic logic [EXT_MAX_W-1:0] extend(
        input logic [EXT_MAX_W-1:0] data,
        input int                   data_w,
        input logic                 sign_ext
    );
        logic [EXT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < EXT_MAX_W; i++) begin
            if (i < data_w) begin
                r[i] = data[i];
            end else if (sign_ext) begin
                r[i] = data[data_w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/banked_sram_buffer_bank.sv
// ----------------------------------------------------------------------------
// bank_sram_1p
// Behavioural single-port SRAM macro model, one bank of the buffer.
// Ports:
//   CK   clock
//   CS   chip select; no access when low
//   WEB  write enable, active low (0 = write, 1 = read)
//   BWE  per-byte write enables, 1 = write that byte
//   A    word address within the bank
//   DI   write data
//   DO   read data, valid the cycle after a read; holds its value through
//        idle and write cycles
// ----------------------------------------------------------------------------
module bank_sram_1p #(
    parameter int DATA_W     = 16,
    parameter int BANK_DEPTH = 32768
) (
    input  logic                          CK,
    input  logic                          CS,
    input  logic                          WEB,
    input  logic [DATA_W/8-1:0]           BWE,
    input  logic [$clog2(BANK_DEPTH)-1:0] A,
    input  logic [DATA_W-1:0]             DI,
    output logic [DATA_W-1:0]             DO
);

    logic [DATA_W-1:0] mem [BANK_DEPTH];

    // NOTE: the array and DO have no reset; a reset port on a RAM array would
    // turn it into flops, and the macro being modelled does not clear anyway.
    always_ff @(posedge CK) begin
        if (CS) begin
            if (!WEB) begin
                for (int i = 0; i < DATA_W/8; i++) begin
                    if (BWE[i]) begin
                        mem[A][i*8 +: 8] <= DI[i*8 +: 8];
                    end
                end
            end else begin
                DO <= mem[A];
            end
        end
    end

endmodule

// File: rtl/banked_sram_buffer.sv
// ----------------------------------------------------------------------------
// banked_sram_buffer
// NUM_BANKS x BANK_DEPTH word activation buffer built from single-port banks.
// The upper address bits select a bank. Reads return in order through a
// RSP_DEPTH-entry response FIFO; writes are byte-masked and produce no
// response; out-of-range reads return err=1 with zero data.
// Ports:
//   clk_i                   clock
//   rst_i                   asynchronous reset, active high
//   req_valid_i/req_ready_o request handshake (ready is a registered credit)
//   req_we_i                1 = write, 0 = read
//   req_addr_i              word address
//   req_wdata_i/req_wmask_i write data and byte enables
//   rsp_valid_o/rsp_ready_i read response handshake
//   rsp_rdata_o             read data extended to OUT_W (0 when no response)
//   rsp_err_o               read address was out of range
// Read timing: accept in T, bank read at posedge T+1, FIFO push at posedge
// T+2, so rsp_valid_o rises at the earliest in T+2.
// Assumes ADDR_W > clog2(BANK_DEPTH) and OUT_W <= EXT_MAX_W.
// ----------------------------------------------------------------------------
module banked_sram_buffer
    import sram_buf_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BANK_DEPTH = DEF_BANK_DEPTH,
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter bit SIGN_EXT   = 1'b1,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_wmask_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [OUT_W-1:0]      rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int OFS_W = $clog2(BANK_DEPTH);
    localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    // One bit wider than the address so a fully populated space still compares.
    localparam logic [ADDR_W:0] TOTAL_WORDS = (ADDR_W+1)'(NUM_BANKS * BANK_DEPTH);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             err;
    } fifo_entry_t;

    // ---------------- request decode ----------------
    logic             req_ready_q, req_ready_d;
    logic             accept, rd_accept, in_range;
    logic [SEL_W-1:0] bank_sel;
    logic [OFS_W-1:0] bank_ofs;

    assign accept    = req_valid_i && req_ready_q;
    assign rd_accept = accept && !req_we_i;
    assign in_range  = ({1'b0, req_addr_i} < TOTAL_WORDS);
    assign bank_sel  = SEL_W'(req_addr_i >> OFS_W);
    assign bank_ofs  = req_addr_i[OFS_W-1:0];

    // ---------------- banks ----------------
    logic [NUM_BANKS-1:0] bank_cs;
    logic [DATA_W-1:0]    bank_do [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        // Out-of-range requests select no bank, so such writes are dropped.
        assign bank_cs[b] = accept && in_range && (bank_sel == SEL_W'(b));

        bank_sram_1p #(
            .DATA_W     (DATA_W),
            .BANK_DEPTH (BANK_DEPTH)
        ) u_bank (
            .CK  (clk_i),
            .CS  (bank_cs[b]),
            .WEB (!req_we_i),
            .BWE (req_wmask_i),
            .A   (bank_ofs),
            .DI  (req_wdata_i),
            .DO  (bank_do[b])
        );
    end

    // ---------------- s1 stage and output mux ----------------
    logic             s1_valid_q, s1_valid_d;
    logic             s1_err_q,   s1_err_d;
    logic [SEL_W-1:0] s1_bank_q,  s1_bank_d;
    logic [DATA_W-1:0] rd_mux;
    fifo_entry_t      push_entry;

    // NOTE: every always_comb output gets a default before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (s1_bank_q == SEL_W'(b)) begin
                rd_mux = bank_do[b];
            end
        end
        push_entry.err  = s1_err_q;
        push_entry.data = s1_err_q ? '0
                        : OUT_W'(extend(EXT_MAX_W'(rd_mux), DATA_W, SIGN_EXT));
    end

    // ---------------- response FIFO and credits ----------------
    fifo_entry_t      fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             push, pop;

    assign push = s1_valid_q;
    assign pop  = (fifo_cnt_q != '0) && rsp_ready_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        s1_valid_d = rd_accept;
        s1_bank_d  = bank_sel;
        s1_err_d   = !in_range;

        // Outstanding reads cover both the s1 stage and the FIFO, so keeping
        // this below RSP_DEPTH is what makes FIFO overflow impossible.
        out_cnt_d = out_cnt_q;
        if (rd_accept && !pop) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (!rd_accept && pop) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end
        req_ready_d = (out_cnt_d < CNT_W'(RSP_DEPTH));

        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_ready_q <= 1'b0;
            out_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_bank_q   <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            req_ready_q <= req_ready_d;
            out_cnt_q   <= out_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_err_q    <= s1_err_d;
            s1_bank_q   <= s1_bank_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    // Data is forced to zero whenever the FIFO is empty, which also covers
    // reset without clearing the storage.
    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign rsp_rdata_o = rsp_valid_o ? fifo_mem[rd_ptr_q].data : '0;
    assign rsp_err_o   = rsp_valid_o ? fifo_mem[rd_ptr_q].err  : 1'b0;

endmodule

// File: tb/tb_banked_sram_buffer.sv
// ----------------------------------------------------------------------------
// tb_banked_sram_buffer
// Directed bench for banked_sram_buffer in its default configuration
// (6 banks x 32768 x 16b, 18-bit address, 32-bit sign-extended responses,
// 3 outstanding reads). A table of single transactions covers addressing,
// masking and range errors; hand-written sequences cover latency, ordering,
// credit back-pressure, streaming rate and reset mid-stream.
// ----------------------------------------------------------------------------
module tb_banked_sram_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    banked_sram_buffer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wmask_i (req_wmask),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Steps to 1 time unit after the next rising edge, where outputs are
    // sampled and inputs changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and returns right after the edge that accepts it.
    task automatic issue(input logic we, input logic [17:0] addr,
                         input logic [15:0] wd, input logic [1:0] wm);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = wm;
        for (int c = 0; c < 50; c++) begin
            if (req_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        req_valid = 1'b0;
        check("accept_in_time", 64'(ok), 64'd1);
    endtask

    // Waits for a response with rsp_ready high and pops it.
    task automatic get_rsp(output logic [31:0] d, output logic e);
        bit ok;
        ok        = 1'b0;
        d         = '0;
        e         = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) begin
                d  = rsp_rdata;
                e  = rsp_err;
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        check("rsp_in_time", 64'(ok), 64'd1);
    endtask

    typedef struct {
        logic        we;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wmask;
        logic [31:0] exp_data;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t        vecs [18];
    logic [17:0] s_addr [5];
    logic [31:0] s_exp  [5];
    logic [31:0] d;
    logic        e;
    bit          acc;
    int          idx, got, issued, first, last, stalls, spurious;
    logic [31:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 18'h00000, 16'h8001, 2'b11, 32'h0,        1'b0, "wr_bank0"};
        vecs[1]  = '{1'b0, 18'h00000, 16'h0,    2'b00, 32'hFFFF8001, 1'b0, "rd_bank0_sext"};
        vecs[2]  = '{1'b1, 18'h08000, 16'h1234, 2'b11, 32'h0,        1'b0, "wr_bank1"};
        vecs[3]  = '{1'b1, 18'h28000, 16'h5678, 2'b11, 32'h0,        1'b0, "wr_bank5"};
        vecs[4]  = '{1'b0, 18'h08000, 16'h0,    2'b00, 32'h00001234, 1'b0, "rd_bank1"};
        vecs[5]  = '{1'b0, 18'h28000, 16'h0,    2'b00, 32'h00005678, 1'b0, "rd_bank5"};
        vecs[6]  = '{1'b0, 18'h30000, 16'h0,    2'b00, 32'h0,        1'b1, "rd_oor_first"};
        vecs[7]  = '{1'b0, 18'h3FFFF, 16'h0,    2'b00, 32'h0,        1'b1, "rd_oor_max"};
        vecs[8]  = '{1'b1, 18'h30000, 16'hDEAD, 2'b11, 32'h0,        1'b0, "wr_oor"};
        vecs[9]  = '{1'b0, 18'h00000, 16'h0,    2'b00, 32'hFFFF8001, 1'b0, "oor_wr_bank0_kept"};
        vecs[10] = '{1'b0, 18'h28000, 16'h0,    2'b00, 32'h00005678, 1'b0, "oor_wr_bank5_kept"};
        vecs[11] = '{1'b1, 18'h2FFFF, 16'h7FFF, 2'b11, 32'h0,        1'b0, "wr_last_word"};
        vecs[12] = '{1'b0, 18'h2FFFF, 16'h0,    2'b00, 32'h00007FFF, 1'b0, "rd_last_word"};
        vecs[13] = '{1'b1, 18'h00010, 16'h00CD, 2'b11, 32'h0,        1'b0, "wr_full"};
        vecs[14] = '{1'b1, 18'h00010, 16'hAB00, 2'b10, 32'h0,        1'b0, "wr_mask_hi"};
        vecs[15] = '{1'b0, 18'h00010, 16'h0,    2'b00, 32'hFFFFABCD, 1'b0, "rd_mask_hi"};
        vecs[16] = '{1'b1, 18'h00010, 16'h1111, 2'b01, 32'h0,        1'b0, "wr_mask_lo"};
        vecs[17] = '{1'b0, 18'h00010, 16'h0,    2'b00, 32'hFFFFAB11, 1'b0, "rd_mask_lo"};

        s_addr = '{18'h00000, 18'h08000, 18'h28000, 18'h00010, 18'h2FFFF};
        s_exp  = '{32'hFFFF8001, 32'h00001234, 32'h00005678, 32'hFFFFAB11, 32'h00007FFF};

        // ---- reset state ----
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;
        step();
        step();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        rst = 1'b0;
        step();
        check("ready_after_rst", 64'(req_ready), 64'd1);

        // ---- table of single transactions ----
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            if (!vecs[i].we) begin
                get_rsp(d, e);
                check({vecs[i].name, "_data"}, 64'(d), 64'(vecs[i].exp_data));
                check({vecs[i].name, "_err"},  64'(e), 64'(vecs[i].exp_err));
            end
        end

        // ---- read latency: valid exactly two cycles after accept ----
        issue(1'b1, 18'h00040, 16'h8001, 2'b11);
        issue(1'b0, 18'h00040, 16'h0, 2'b00);
        check("lat_t1_valid", 64'(rsp_valid), 64'd0);
        step();
        check("lat_t2_valid", 64'(rsp_valid), 64'd1);
        check("lat_t2_data",  64'(rsp_rdata), 64'hFFFF8001);
        check("lat_t2_err",   64'(rsp_err),   64'd0);
        step();
        check("lat_popped",   64'(rsp_valid), 64'd0);

        // ---- back-to-back reads to two banks, in order ----
        req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h08000;
        check("b2b_ready0", 64'(req_ready), 64'd1);
        step();
        req_addr = 18'h28000;
        check("b2b_ready1", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        check("b2b_first_valid", 64'(rsp_valid), 64'd1);
        check("b2b_first_data",  64'(rsp_rdata), 64'h00001234);
        step();
        check("b2b_second_valid", 64'(rsp_valid), 64'd1);
        check("b2b_second_data",  64'(rsp_rdata), 64'h00005678);
        step();
        check("b2b_drained", 64'(rsp_valid), 64'd0);

        // ---- read-after-write in consecutive cycles ----
        req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00030;
        req_wdata = 16'h4242; req_wmask = 2'b11;
        step();
        req_we = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        check("raw_valid", 64'(rsp_valid), 64'd1);
        check("raw_data",  64'(rsp_rdata), 64'h00004242);
        step();

        // ---- credit limit with rsp_ready low ----
        rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = (idx < 5);
            req_we    = 1'b0;
            req_addr  = s_addr[idx % 5];
            acc       = req_valid && req_ready;
            step();
            if (acc) idx++;
        end
        check("credit_accepted", 64'(idx), 64'd3);
        check("credit_ready_low", 64'(req_ready), 64'd0);
        check("credit_rsp_valid", 64'(rsp_valid), 64'd1);
        held = rsp_rdata;
        check("credit_head_data", 64'(held), 64'(s_exp[0]));
        step();
        step();
        check("credit_hold_data", 64'(rsp_rdata), 64'(held));
        check("credit_hold_err",  64'(rsp_err),   64'd0);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && (got < 5 || idx < 5); c++) begin
            req_valid = (idx < 5);
            req_addr  = s_addr[idx % 5];
            acc       = req_valid && req_ready;
            if (rsp_valid && got < 5) begin
                check($sformatf("credit_rsp%0d", got), 64'(rsp_rdata), 64'(s_exp[got]));
                got++;
            end
            step();
            if (acc) idx++;
        end
        req_valid = 1'b0;
        check("credit_all_accepted", 64'(idx), 64'd5);
        check("credit_all_returned", 64'(got), 64'd5);
        step();
        step();

        // ---- streaming 64 reads at full rate ----
        issued = 0; got = 0; first = -1; last = -1; stalls = 0;
        for (int c = 0; c < 200 && got < 64; c++) begin
            req_valid = (issued < 64);
            req_addr  = s_addr[issued % 5];
            acc       = req_valid && req_ready;
            if (req_valid && !req_ready) stalls++;
            if (rsp_valid) begin
                check($sformatf("stream_rsp%0d", got), 64'(rsp_rdata), 64'(s_exp[got % 5]));
                if (first < 0) first = c;
                last = c;
                got++;
            end
            step();
            if (acc) issued++;
        end
        req_valid = 1'b0;
        check("stream_issued", 64'(issued), 64'd64);
        check("stream_returned", 64'(got), 64'd64);
        check("stream_stalls", 64'(stalls), 64'd0);
        check("stream_one_per_cycle", 64'(last - first + 1), 64'd64);

        // ---- reset mid-stream ----
        issued = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_addr  = s_addr[c % 5];
            step();
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        step();
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (rsp_valid) spurious++;
        end
        check("midrst_no_spurious", 64'(spurious), 64'd0);
        check("midrst_ready_back", 64'(req_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
